// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Brief    : Shared constants and sequencer state type for the 4-bit CPU core.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int ADDR_W     = 12;
    localparam int CW_W       = 13;
    localparam int INCPC_BIT  = 12;
    localparam int LOADPC_BIT = 11;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// Module   : fetch_sequencer
// Brief    : Two-phase fetch/execute sequencer with run/halt/step and PC breakpoint.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int CW_W       = cpu_pkg::CW_W,
    parameter int INCPC_BIT  = cpu_pkg::INCPC_BIT,
    parameter int LOADPC_BIT = cpu_pkg::LOADPC_BIT,
    parameter int CNT_W      = cpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [7:0]        rom_data,
    input  logic [CW_W-1:0]   ctrl_word,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              phase,
    output logic              cw_valid,
    output logic              halted,
    output logic              retired,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  instr_cnt
);

    import cpu_pkg::*;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              step_mode_q, step_mode_d;
    logic              halt_pend_q, halt_pend_d;
    logic              bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] next_pc;
    logic              bp_match;
    logic              stop_req;

    always_comb begin
        // Jump target is the IR operand nibble followed by the byte after the opcode.
        next_pc = pc_q;
        if (ctrl_word[LOADPC_BIT]) begin
            next_pc = ADDR_W'({ir_q[3:0], rom_data});
        end else if (ctrl_word[INCPC_BIT]) begin
            next_pc = pc_q + ADDR_W'(1);
        end

        bp_match = bp_en && (next_pc == bp_addr);
        stop_req = step_mode_q | halt_req | halt_pend_q | ~run_en | bp_match;

        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        step_mode_d = step_mode_q;
        halt_pend_d = halt_pend_q;
        bp_hit_d    = bp_hit_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (run_en || step_req) begin
                    state_d     = FETCH;
                    step_mode_d = step_req & ~run_en;
                    halt_pend_d = 1'b0;
                    bp_hit_d    = 1'b0;
                end
            end
            FETCH: begin
                ir_d    = rom_data;
                pc_d    = next_pc;
                state_d = EXEC;
                // A halt pulse seen mid-instruction is held until the boundary.
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
            end
            EXEC: begin
                pc_d        = next_pc;
                cnt_d       = cnt_q + CNT_W'(1);
                step_mode_d = 1'b0;
                halt_pend_d = 1'b0;
                if (stop_req) begin
                    state_d  = IDLE;
                    bp_hit_d = bp_hit_q | bp_match;
                end else begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            step_mode_q <= 1'b0;
            halt_pend_q <= 1'b0;
            bp_hit_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            step_mode_q <= step_mode_d;
            halt_pend_q <= halt_pend_d;
            bp_hit_q    <= bp_hit_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign opcode    = ir_q[7:4];
    assign operand   = ir_q[3:0];
    assign phase     = (state_q == EXEC);
    assign cw_valid  = (state_q != IDLE);
    assign halted    = (state_q == IDLE);
    assign retired   = (state_q == EXEC);
    assign bp_hit    = bp_hit_q;
    assign instr_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench: directed table, corner sequences, random vs model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              run_en, step_req, halt_req, bp_en;
    logic [11:0]       bp_addr;
    logic [7:0]        rom_data;
    logic [12:0]       ctrl_word;
    logic [11:0]       pc;
    logic [3:0]        opcode, operand;
    logic              phase, cw_valid, halted, retired, bp_hit;
    logic [15:0]       instr_cnt;

    logic [7:0]        rom [0:4095];
    int                n_cmp = 0;
    int                n_fail = 0;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .run_en(run_en), .step_req(step_req),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .rom_data(rom_data), .ctrl_word(ctrl_word), .pc(pc), .opcode(opcode),
        .operand(operand), .phase(phase), .cw_valid(cw_valid), .halted(halted),
        .retired(retired), .bp_hit(bp_hit), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[pc];

    // Toy decoder: FETCH always increments; EXEC depends on the opcode.
    // C = JMP (load), 9 = load+inc (load wins), 8 = two-byte skip, others hold.
    always_comb begin
        ctrl_word = '0;
        if (!phase) begin
            ctrl_word[INCPC_BIT] = 1'b1;
        end else begin
            case (opcode)
                4'hC: ctrl_word[LOADPC_BIT] = 1'b1;
                4'h9: begin
                    ctrl_word[LOADPC_BIT] = 1'b1;
                    ctrl_word[INCPC_BIT]  = 1'b1;
                end
                4'h8: ctrl_word[INCPC_BIT] = 1'b1;
                default: ctrl_word = '0;
            endcase
        end
    end

    typedef struct {
        logic [11:0] start;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] exp_pc;
        logic [3:0]  exp_op;
        logic [3:0]  exp_opnd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run_en = 0; step_req = 0; halt_req = 0; bp_en = 0; bp_addr = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic step_one();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [11:0] m_pc, p1, nxt;
        logic [7:0]  ir;
        logic [15:0] m_cnt;
        bit          m_running, m_step, m_bp, run, halt, hf, stop;
        bit          seen;

        tbl[0] = '{12'h020, 8'h40, 8'h00, 12'h021, 4'h4, 4'h0};
        tbl[1] = '{12'hFFF, 8'h40, 8'h00, 12'h000, 4'h4, 4'h0};
        tbl[2] = '{12'hFFE, 8'h80, 8'h00, 12'h000, 4'h8, 4'h0};
        tbl[3] = '{12'h100, 8'hC1, 8'h23, 12'h123, 4'hC, 4'h1};
        tbl[4] = '{12'hFFE, 8'hC5, 8'h67, 12'h567, 4'hC, 4'h5};
        tbl[5] = '{12'h7A0, 8'h9A, 8'hBC, 12'hABC, 4'h9, 4'hA};
        tbl[6] = '{12'h300, 8'h80, 8'h55, 12'h302, 4'h8, 4'h0};
        tbl[7] = '{12'h200, 8'h0F, 8'h00, 12'h201, 4'h0, 4'hF};

        for (int i = 0; i < 4096; i++) rom[i] = 8'h40;

        // Reset state
        reset = 1'b1;
        run_en = 0; step_req = 0; halt_req = 0; bp_en = 0; bp_addr = '0;
        tick();
        reset = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_ir", {opcode, operand}, 0);
        chk("rst_phase", phase, 0);
        chk("rst_cw_valid", cw_valid, 0);
        chk("rst_halted", halted, 1);
        chk("rst_retired", retired, 0);
        chk("rst_bp_hit", bp_hit, 0);
        chk("rst_cnt", instr_cnt, 0);

        // Free run over LIT: pc k in FETCH, k+1 in EXEC, retired alternates
        run_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("run_fetch_pc", pc, k);
            chk("run_fetch_ret", retired, 0);
            tick();
            chk("run_exec_pc", pc, k + 1);
            chk("run_exec_ret", retired, 1);
        end
        tick();
        chk("run_cnt", instr_cnt, 4);

        // Directed single-instruction table: jump to start, then step the vector
        foreach (tbl[i]) begin
            do_reset();
            rom[0] = {4'hC, tbl[i].start[11:8]};
            rom[1] = tbl[i].start[7:0];
            rom[tbl[i].start] = tbl[i].b0;
            if (tbl[i].start != 12'hFFF) rom[tbl[i].start + 12'd1] = tbl[i].b1;
            step_one();
            chk("tbl_jump_pc", pc, tbl[i].start);
            step_one();
            chk("tbl_pc", pc, tbl[i].exp_pc);
            chk("tbl_opcode", opcode, tbl[i].exp_op);
            chk("tbl_operand", operand, tbl[i].exp_opnd);
            chk("tbl_cnt", instr_cnt, 2);
            chk("tbl_halted", halted, 1);
            rom[0] = 8'h40;
            rom[1] = 8'h40;
            rom[tbl[i].start] = 8'h40;
            rom[tbl[i].start + 12'd1] = 8'h40;
        end

        // Breakpoint at 0x005 on linear code, then single-step past it
        do_reset();
        bp_en = 1'b1;
        bp_addr = 12'h005;
        run_en = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (halted) seen = 1;
        end
        run_en = 1'b0;
        chk("bp_stopped", seen, 1);
        chk("bp_hit", bp_hit, 1);
        chk("bp_pc", pc, 12'h005);
        chk("bp_cnt", instr_cnt, 5);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("bp_cleared", bp_hit, 0);
        tick();
        tick();
        chk("step_halted", halted, 1);
        chk("step_pc", pc, 12'h006);
        chk("step_cnt", instr_cnt, 6);
        chk("step_no_retrig", bp_hit, 0);
        bp_en = 1'b0;

        // halt_req pulse during FETCH: instruction completes, then IDLE holds pc
        do_reset();
        run_en = 1'b1;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_exec_ret", retired, 1);
        tick();
        run_en = 1'b0;
        chk("halt_idle", halted, 1);
        chk("halt_pc", pc, 1);
        chk("halt_cnt", instr_cnt, 1);
        tick();
        tick();
        chk("idle_pc_hold", pc, 1);
        chk("idle_halted", halted, 1);

        // JMP 0x123 then asynchronous reset in EXEC of a second jump
        do_reset();
        rom[0] = 8'hC1; rom[1] = 8'h23; rom[12'h123] = 8'hC0; rom[12'h124] = 8'h00;
        run_en = 1'b1;
        tick();
        tick();
        tick();
        chk("jmp_pc", pc, 12'h123);
        chk("jmp_cnt", instr_cnt, 1);
        tick();
        chk("jmp2_phase", phase, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_halted", halted, 1);
        chk("arst_cw_valid", cw_valid, 0);
        chk("arst_cnt", instr_cnt, 0);
        chk("arst_ir", {opcode, operand}, 0);
        run_en = 1'b0;
        tick();
        reset = 1'b0;

        // Randomized instructions against an instruction-level model
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        do_reset();
        m_pc = '0; m_cnt = '0; m_running = 0;
        for (int it = 0; it < 300; it++) begin
            run  = ($urandom_range(3) != 0);
            halt = ($urandom_range(5) == 0);
            hf   = 1'($urandom_range(1));
            ir   = rom[m_pc];
            p1   = m_pc + 12'd1;
            case (ir[7:4])
                4'hC, 4'h9: nxt = {ir[3:0], rom[p1]};
                4'h8:       nxt = p1 + 12'd1;
                default:    nxt = p1;
            endcase
            bp_en   = 1'($urandom_range(1));
            bp_addr = ($urandom_range(2) == 0) ? nxt : 12'($urandom);
            if (!m_running) begin
                m_step   = !run;
                run_en   = run;
                step_req = !run;
                tick();
                step_req = 1'b0;
                chk("rnd_start_valid", cw_valid, 1);
                chk("rnd_start_bp", bp_hit, 0);
            end else begin
                m_step   = 0;
                run_en   = run;
                step_req = 1'($urandom_range(1));
            end
            halt_req = halt & hf;
            tick();
            halt_req = halt & !hf;
            step_req = 1'b0;
            chk("rnd_fetch_pc", pc, p1);
            chk("rnd_ir", {opcode, operand}, ir);
            chk("rnd_exec_ret", retired, 1);
            tick();
            halt_req = 1'b0;
            m_cnt++;
            m_bp = bp_en && (nxt == bp_addr);
            stop = m_step | halt | !run | m_bp;
            chk("rnd_pc", pc, nxt);
            chk("rnd_cnt", instr_cnt, m_cnt);
            chk("rnd_halted", halted, stop);
            chk("rnd_bp_hit", bp_hit, m_bp);
            chk("rnd_ret_low", retired, 0);
            m_running = !stop;
            m_pc = nxt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
